// File: rtl/cmos_counter_pkg.sv
`timescale 1ns/1ps
// Shared constants for the switch-level counter slice.
package cmos_counter_pkg;
  localparam int unsigned CMOS_CNT_WIDTH_DEFAULT = 4;
  localparam int unsigned CMOS_CNT_WIDTH_MAX     = 8;
endpackage

// File: rtl/cmos_dffr.sv
`timescale 1ns/1ps
// Switch-level master-slave D flip-flop, rising-edge, active-low async clear.
// Each latch is a gated cross-coupled NOR pair built from pmos/nmos only.
module cmos_dffr (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output wire  q,
  input  wire  vdd,
  input  wire  gnd
);
  wire clk_n, clr;
  wire m_dn, m_x, m_s, m_q, m_qn;
  wire m_x1, m_s1, m_s2, m_q1, m_q2, m_qn1;
  wire s_dn, s_x, s_s, s_qn;
  wire s_x1, s_s1, s_s2, s_q1, s_q2, s_qn1;

  pmos (clk_n, vdd, clk);   nmos (clk_n, gnd, clk);
  pmos (clr, vdd, rst_n);   nmos (clr, gnd, rst_n);

  // Master opens while clk = 0; clk itself is its active-low gate so it shuts
  // before the slave (one inverter later) can open on the rising edge.
  pmos (m_dn, vdd, d);      nmos (m_dn, gnd, d);
  pmos (m_x1, vdd, clk);    pmos (m_x, m_x1, d);
  nmos (m_x, gnd, clk);     nmos (m_x, gnd, d);
  pmos (m_s1, vdd, clk);    pmos (m_s2, m_s1, m_dn);  pmos (m_s, m_s2, clr);
  nmos (m_s, gnd, clk);     nmos (m_s, gnd, m_dn);    nmos (m_s, gnd, clr);
  pmos (m_q1, vdd, m_x);    pmos (m_q2, m_q1, clr);   pmos (m_q, m_q2, m_qn);
  nmos (m_q, gnd, m_x);     nmos (m_q, gnd, clr);     nmos (m_q, gnd, m_qn);
  pmos (m_qn1, vdd, m_s);   pmos (m_qn, m_qn1, m_q);
  nmos (m_qn, gnd, m_s);    nmos (m_qn, gnd, m_q);

  // Slave opens while clk = 1 and shuts before the master reopens.
  pmos (s_dn, vdd, m_q);    nmos (s_dn, gnd, m_q);
  pmos (s_x1, vdd, clk_n);  pmos (s_x, s_x1, m_q);
  nmos (s_x, gnd, clk_n);   nmos (s_x, gnd, m_q);
  pmos (s_s1, vdd, clk_n);  pmos (s_s2, s_s1, s_dn);  pmos (s_s, s_s2, clr);
  nmos (s_s, gnd, clk_n);   nmos (s_s, gnd, s_dn);    nmos (s_s, gnd, clr);
  pmos (s_q1, vdd, s_x);    pmos (s_q2, s_q1, clr);   pmos (q, s_q2, s_qn);
  nmos (q, gnd, s_x);       nmos (q, gnd, clr);       nmos (q, gnd, s_qn);
  pmos (s_qn1, vdd, s_s);   pmos (s_qn, s_qn1, q);
  nmos (s_qn, gnd, s_s);    nmos (s_qn, gnd, q);
endmodule

// File: rtl/cmos_counter.sv
`timescale 1ns/1ps
// Switch-level WIDTH-bit up-counter with parallel load and terminal count.
// Next-state logic is NOR/INV only; the ripple carry out of the MSB is tc.
module cmos_counter
  import cmos_counter_pkg::*;
#(
  parameter int unsigned WIDTH = CMOS_CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output wire  [WIDTH-1:0] q,
  output wire              tc,
  input  wire              vdd,
  input  wire              gnd
);
  wire             load_n;
  wire [WIDTH:0]   carry;

  pmos (load_n, vdd, load);  nmos (load_n, gnd, load);

  assign carry[0] = en;
  // c_WIDTH = en & q_0 & ... & q_{WIDTH-1}, which is exactly the terminal count.
  assign tc = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wire q_b, cin, cout, n1, n2, n3, xn, sum, dn, t1, t2, nx_n, nx;
    wire n1_m, n2_m, n3_m, xn_m, co_m, t1_m, t2_m, nx_m;

    assign cin = carry[i];

    // Four-NOR XNOR; n1 is reused for the carry.
    pmos (n1_m, vdd, q_b);  pmos (n1, n1_m, cin);
    nmos (n1, gnd, q_b);    nmos (n1, gnd, cin);
    pmos (n2_m, vdd, q_b);  pmos (n2, n2_m, n1);
    nmos (n2, gnd, q_b);    nmos (n2, gnd, n1);
    pmos (n3_m, vdd, cin);  pmos (n3, n3_m, n1);
    nmos (n3, gnd, cin);    nmos (n3, gnd, n1);
    pmos (xn_m, vdd, n2);   pmos (xn, xn_m, n3);
    nmos (xn, gnd, n2);     nmos (xn, gnd, n3);
    pmos (sum, vdd, xn);    nmos (sum, gnd, xn);

    // cout = nor(~q & ~c, q ^ c) = q & c
    pmos (co_m, vdd, n1);   pmos (cout, co_m, sum);
    nmos (cout, gnd, n1);   nmos (cout, gnd, sum);

    // Load mux: t1 = load & d, t2 = ~load & sum.
    pmos (dn, vdd, d[i]);   nmos (dn, gnd, d[i]);
    pmos (t1_m, vdd, load_n);  pmos (t1, t1_m, dn);
    nmos (t1, gnd, load_n);    nmos (t1, gnd, dn);
    pmos (t2_m, vdd, load);    pmos (t2, t2_m, xn);
    nmos (t2, gnd, load);      nmos (t2, gnd, xn);
    pmos (nx_m, vdd, t1);   pmos (nx_n, nx_m, t2);
    nmos (nx_n, gnd, t1);   nmos (nx_n, gnd, t2);
    pmos (nx, vdd, nx_n);   nmos (nx, gnd, nx_n);

    cmos_dffr u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (nx),
      .q     (q_b),
      .vdd   (vdd),
      .gnd   (gnd)
    );

    assign q[i]         = q_b;
    assign carry[i + 1] = cout;
  end
endmodule

// File: tb/tb_cmos_counter.sv
`timescale 1ns/1ps
// Directed and randomised checks of cmos_counter at WIDTH = 2, 4 and 8.
module tb_cmos_counter;
  supply1 vdd;
  supply0 gnd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en4 = 1'b0, load4 = 1'b0;
  logic [3:0] d4 = '0;
  logic       en2 = 1'b0, load2 = 1'b0;
  logic [1:0] d2 = '0;
  logic       en8 = 1'b0, load8 = 1'b0;
  logic [7:0] d8 = '0;
  wire  [3:0] q4;
  wire  [1:0] q2;
  wire  [7:0] q8;
  wire        tc4, tc2, tc8;

  logic [3:0] r4;
  logic [1:0] r2;
  logic [7:0] r8;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cmos_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .load(load4), .d(d4), .q(q4), .tc(tc4),
    .vdd(vdd), .gnd(gnd)
  );
  cmos_counter #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .load(load2), .d(d2), .q(q2), .tc(tc2),
    .vdd(vdd), .gnd(gnd)
  );
  cmos_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .load(load8), .d(d8), .q(q8), .tc(tc8),
    .vdd(vdd), .gnd(gnd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (q4 !== 4'h0) $display("FAIL reset_q4: got %h want %h", q4, 4'h0); else passed++;
    checks++; if (q2 !== 2'h0) $display("FAIL reset_q2: got %h want %h", q2, 2'h0); else passed++;
    checks++; if (q8 !== 8'h0) $display("FAIL reset_q8: got %h want %h", q8, 8'h0); else passed++;
    checks++; if (tc4 !== 1'b0) $display("FAIL reset_tc4: got %b want 0", tc4); else passed++;
    #1 rst_n = 1'b1;
    en4 = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (q4 !== 4'h9) $display("FAIL count_to_9: got %h want %h", q4, 4'h9); else passed++;
    #2 rst_n = 1'b0;
    #0.001;
    checks++; if (q4 !== 4'h0) $display("FAIL async_clr_q: got %h want %h", q4, 4'h0); else passed++;
    checks++; if (tc4 !== 1'b0) $display("FAIL async_clr_tc: got %b want 0", tc4); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q4 !== 4'h0) $display("FAIL held_in_reset[%0d]: got %h want 0", i, q4); else passed++;
    end
    en4 = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp;
    en4 = 1'b1;
    load4 = 1'b0;
    #1;
    checks++; if (tc4 !== 1'b0) $display("FAIL tc_at_zero: got %b want 0", tc4); else passed++;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp = 4'(i % 16);
      checks++;
      if (q4 !== exp) $display("FAIL count_q[%0d]: got %h want %h", i, q4, exp); else passed++;
      checks++;
      if (tc4 !== (exp == 4'hF))
        $display("FAIL count_tc[%0d]: got %b want %b", i, tc4, exp == 4'hF);
      else passed++;
    end
    en4 = 1'b0;
  endtask

  task automatic test_load_priority();
    load4 = 1'b1; d4 = 4'h3; en4 = 1'b0;
    tick();
    checks++; if (q4 !== 4'h3) $display("FAIL load_3: got %h want %h", q4, 4'h3); else passed++;
    en4 = 1'b1; d4 = 4'hA;
    tick();
    checks++; if (q4 !== 4'hA) $display("FAIL load_over_en: got %h want %h", q4, 4'hA); else passed++;
    load4 = 1'b0;
    tick();
    checks++; if (q4 !== 4'hB) $display("FAIL inc_after_load: got %h want %h", q4, 4'hB); else passed++;
    en4 = 1'b0;
  endtask

  task automatic test_hold();
    load4 = 1'b1; d4 = 4'h7;
    tick();
    checks++; if (q4 !== 4'h7) $display("FAIL hold_load7: got %h want %h", q4, 4'h7); else passed++;
    load4 = 1'b0; en4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (q4 !== 4'h7) $display("FAIL hold_q[%0d]: got %h want 7", i, q4); else passed++;
      checks++; if (tc4 !== 1'b0) $display("FAIL hold_tc[%0d]: got %b want 0", i, tc4); else passed++;
    end
    load4 = 1'b1; d4 = 4'hF;
    tick();
    load4 = 1'b0;
    #1;
    checks++; if (q4 !== 4'hF) $display("FAIL hold_loadF: got %h want %h", q4, 4'hF); else passed++;
    checks++; if (tc4 !== 1'b0) $display("FAIL tc_en_low: got %b want 0", tc4); else passed++;
    en4 = 1'b1;
    #1;
    checks++; if (tc4 !== 1'b1) $display("FAIL tc_comb_rise: got %b want 1", tc4); else passed++;
    en4 = 1'b0;
    #1;
    checks++; if (tc4 !== 1'b0) $display("FAIL tc_comb_fall: got %b want 0", tc4); else passed++;
  endtask

  task automatic test_width_sweep();
    load2 = 1'b1; d2 = 2'h3; load8 = 1'b1; d8 = 8'hFF;
    tick();
    checks++; if (q2 !== 2'h3) $display("FAIL w2_load: got %h want %h", q2, 2'h3); else passed++;
    checks++; if (q8 !== 8'hFF) $display("FAIL w8_load: got %h want %h", q8, 8'hFF); else passed++;
    load2 = 1'b0; load8 = 1'b0; en2 = 1'b1; en8 = 1'b1;
    #1;
    checks++; if (tc2 !== 1'b1) $display("FAIL w2_tc: got %b want 1", tc2); else passed++;
    checks++; if (tc8 !== 1'b1) $display("FAIL w8_tc: got %b want 1", tc8); else passed++;
    tick();
    checks++; if (q2 !== 2'h0) $display("FAIL w2_wrap: got %h want 0", q2); else passed++;
    checks++; if (q8 !== 8'h0) $display("FAIL w8_wrap: got %h want 0", q8); else passed++;
    checks++; if (tc8 !== 1'b0) $display("FAIL w8_tc_after: got %b want 0", tc8); else passed++;
    r2 = 2'h0; r8 = 8'h0;
    d2 = 2'h2; d8 = 8'h7E;
    for (int k = 0; k < 8; k++) begin
      en2 = (k != 3); en8 = (k != 3);
      load2 = (k == 5); load8 = (k == 5);
      r2 = load2 ? d2 : en2 ? r2 + 2'd1 : r2;
      r8 = load8 ? d8 : en8 ? r8 + 8'd1 : r8;
      tick();
      checks++; if (q2 !== r2) $display("FAIL w2_ref[%0d]: got %h want %h", k, q2, r2); else passed++;
      checks++; if (q8 !== r8) $display("FAIL w8_ref[%0d]: got %h want %h", k, q8, r8); else passed++;
    end
    en2 = 1'b0; en8 = 1'b0; load2 = 1'b0; load8 = 1'b0;
  endtask

  task automatic test_random();
    r4 = q4 === 4'hx ? 4'h0 : 4'hF;
    // Resynchronise the reference through a load on every instance.
    load4 = 1'b1; d4 = 4'h5; load2 = 1'b1; d2 = 2'h1; load8 = 1'b1; d8 = 8'hC3;
    r4 = 4'h5; r2 = 2'h1; r8 = 8'hC3;
    tick();
    for (int n = 0; n < 2000; n++) begin
      checks++; if (q4 !== r4) $display("FAIL rnd_q4[%0d]: got %h want %h", n, q4, r4); else passed++;
      checks++; if (q2 !== r2) $display("FAIL rnd_q2[%0d]: got %h want %h", n, q2, r2); else passed++;
      checks++; if (q8 !== r8) $display("FAIL rnd_q8[%0d]: got %h want %h", n, q8, r8); else passed++;
      en4 = 1'($urandom_range(0, 1)); load4 = ($urandom_range(0, 3) == 0); d4 = 4'($urandom);
      en2 = 1'($urandom_range(0, 1)); load2 = ($urandom_range(0, 3) == 0); d2 = 2'($urandom);
      en8 = 1'($urandom_range(0, 1)); load8 = ($urandom_range(0, 7) == 0); d8 = 8'($urandom);
      #1;
      checks++;
      if (tc4 !== (en4 && r4 == 4'hF))
        $display("FAIL rnd_tc4[%0d]: got %b want %b", n, tc4, en4 && r4 == 4'hF);
      else passed++;
      checks++;
      if (tc2 !== (en2 && r2 == 2'h3))
        $display("FAIL rnd_tc2[%0d]: got %b want %b", n, tc2, en2 && r2 == 2'h3);
      else passed++;
      if ($urandom_range(0, 49) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({q8, q4, q2} !== 14'h0) $display("FAIL rnd_rst[%0d]: got %h want 0", n, {q8, q4, q2});
        else passed++;
        rst_n = 1'b1;
        r4 = 4'h0; r2 = 2'h0; r8 = 8'h0;
      end
      r4 = load4 ? d4 : en4 ? r4 + 4'd1 : r4;
      r2 = load2 ? d2 : en2 ? r2 + 2'd1 : r2;
      r8 = load8 ? d8 : en8 ? r8 + 8'd1 : r8;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_load_priority();
    test_hold();
    test_width_sweep();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
